// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered WIDTH-bit ALU with a start/done handshake.
//
// Every operation except MUL completes in one clock. MUL is a shift-add
// multiplier that takes WIDTH clocks. The carry and borrow flags persist
// between operations so that ADC/SBB can chain multi-word arithmetic.
//
// Ports:
//   clk     in   system clock, all state changes on the rising edge
//   rst     in   synchronous, active-high reset
//   start   in   launch an operation (accepted only while busy = 0)
//   a, b    in   WIDTH-bit operands, sampled on an accepted start
//   mode    in   4-bit opcode, sampled on an accepted start
//   busy    out  a multi-cycle MUL is in progress
//   done    out  one-cycle pulse: result/flags were just written
//   result  out  registered WIDTH-bit result
//   flags   out  [0]=C carry, [1]=B borrow, [2]=Z zero, [3]=LT (a<b unsigned)
//
// Handshake: start is a request that is taken on any rising edge where
// start=1 and busy=0. A request made while busy=1 is dropped, with no
// latching and no effect on the running operation. Each accepted request
// yields exactly one done pulse, unless a reset aborts it. result and flags
// only change on the edge that raises done, so they are stable between pulses.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SBB  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_CLRF = 4'b1110;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q,  flags_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;   // latched a (multiplicand)
    logic [WIDTH-1:0]   b_q,      b_d;       // latched b, kept for LT
    logic [2*WIDTH-1:0] acc_q,    acc_d;     // {partial product, multiplier}
    logic [CNT_W-1:0]   cnt_q,    cnt_d;     // shift-add steps already done

    logic accept;
    assign accept = start && (state_q == S_IDLE);

    // ---------------------------------------------------------------------
    // Single-cycle datapath, working directly on the input operands.
    // C and B default to their registered values so every opcode that does
    // not mention a flag holds it.
    // ---------------------------------------------------------------------
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_b;

    always_comb begin
        add_w = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, (mode == OP_ADC) ? flags_q[0] : 1'b0};
        // Subtract widened by one bit: the top bit is the borrow out.
        sub_w = {1'b0, a} - {1'b0, b}
              - {{WIDTH{1'b0}}, (mode == OP_SBB) ? flags_q[1] : 1'b0};

        alu_res = '0;
        alu_c   = flags_q[0];
        alu_b   = flags_q[1];

        unique case (mode)
            OP_ADD, OP_ADC: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_b   = (a < b);
            end
            OP_SBB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_b   = sub_w[WIDTH];
            end
            OP_SHL: begin
                alu_res = a << 1;
                alu_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = a >> 1;
                alu_c   = a[0];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOT:  alu_res = ~a;
            OP_XOR:  alu_res = a ^ b;
            OP_NAND: alu_res = ~(a & b);
            OP_NOR:  alu_res = ~(a | b);
            OP_ROL: begin
                alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
                alu_c   = a[WIDTH-1];
            end
            OP_CLRF: begin
                alu_res = '0;
                alu_c   = 1'b0;
                alu_b   = 1'b0;
            end
            // MUL never completes through this path; reserved yields 0.
            default: alu_res = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // One shift-add multiplier step. The low half of the accumulator holds
    // the not-yet-consumed multiplier bits, LSB first. When that LSB is set,
    // the multiplicand is added into the high half, and then the whole
    // accumulator, including the adder carry, shifts right one place.
    // The first step runs on the accepting edge, using the raw inputs, so
    // that the WIDTH-th step falls on the completion edge.
    // ---------------------------------------------------------------------
    logic [2*WIDTH-1:0] step_in;
    logic [WIDTH-1:0]   step_mcand;
    logic [WIDTH:0]     step_hi;
    logic [2*WIDTH-1:0] step_out;

    always_comb begin
        if (state_q == S_IDLE) begin
            step_in    = {{WIDTH{1'b0}}, b};
            step_mcand = a;
        end else begin
            step_in    = acc_q;
            step_mcand = mcand_q;
        end
        step_hi  = {1'b0, step_in[2*WIDTH-1:WIDTH]}
                 + (step_in[0] ? {1'b0, step_mcand} : {(WIDTH+1){1'b0}});
        step_out = {step_hi, step_in[WIDTH-1:1]};
    end

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d = a;
                    b_d     = b;
                    if (mode == OP_MUL) begin
                        state_d = S_MUL;
                        acc_d   = step_out;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        result_d = alu_res;
                        flags_d  = {(a < b), (alu_res == '0), alu_b, alu_c};
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = step_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    result_d = step_out[WIDTH-1:0];
                    // C reports a product that overflowed WIDTH bits; B holds.
                    flags_d  = {(mcand_q < b_q),
                                (step_out[WIDTH-1:0] == '0),
                                flags_q[1],
                                (step_out[2*WIDTH-1:WIDTH] != '0)};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= 4'b0000;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == S_MUL);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed, self-checking bench for alu_seq (WIDTH = 8).
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SBB  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_CLRF = 4'b1110;
    localparam logic [3:0] OP_RSVD = 4'b1111;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   mode;
    logic         busy, done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Present one request for one edge and sample #1 after that edge.
    task automatic issue(input logic [3:0] m, input logic [W-1:0] va, input logic [W-1:0] vb);
        start = 1'b1;
        mode  = m;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Single-cycle op: done, result and flags must appear on the accepting edge.
    task automatic op1(input string tag, input logic [3:0] m, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] er, input logic [3:0] ef);
        issue(m, va, vb);
        check({tag, ".done"},   32'(done),   32'd1);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".flags"},  32'(flags),  32'(ef));
    endtask

    // MUL: busy for W-1 cycles after acceptance, done on the W-th edge.
    // A stray start of a different op is pulsed mid-run and must be ignored.
    task automatic op_mul(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] er, input logic [3:0] ef);
        int waited;
        issue(OP_MUL, va, vb);
        check({tag, ".busy_after_start"}, 32'(busy), 32'd1);
        check({tag, ".no_early_done"},    32'(done), 32'd0);
        waited = 1;
        while (!done && waited < 40) begin
            if (waited == 3) begin
                start = 1'b1; mode = OP_ADD; a = 8'h01; b = 8'h01;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            waited++;
        end
        check({tag, ".latency"}, 32'(waited), 32'(W));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".flags"},  32'(flags),  32'(ef));
        // Ignored stray start must not produce an extra done.
        @(posedge clk);
        #1;
        check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ".result_held"},    32'(result), 32'(er));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.result", 32'(result), 32'h0);
        check("reset.flags",  32'(flags),  32'h0);
        check("reset.busy",   32'(busy),   32'd0);
        check("reset.done",   32'(done),   32'd0);
        rst = 1'b0;

        // Carry chain, back-to-back (done on consecutive edges).
        op1("add",  OP_ADD, 8'hF0, 8'h20, 8'h10, 4'b0001);
        op1("adc",  OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000);
        @(posedge clk); #1;
        check("idle.done_low", 32'(done), 32'd0);
        check("idle.result_held", 32'(result), 32'h01);

        // Borrow chain.
        op1("sub",  OP_SUB, 8'h10, 8'h20, 8'hF0, 4'b1010);
        op1("sbb",  OP_SBB, 8'h05, 8'h04, 8'h00, 4'b0100);

        // Multiplier.
        op_mul("mul15x17", 8'd15, 8'd17, 8'hFF, 4'b1000);
        op_mul("mul10x10", 8'h10, 8'h10, 8'h00, 4'b0101);

        // Shifts and logic; C/B held where the op does not touch them.
        op1("shl",  OP_SHL, 8'h81, 8'h00, 8'h02, 4'b0001);
        op1("rol",  OP_ROL, 8'h81, 8'h00, 8'h03, 4'b0001);
        op1("nor",  OP_NOR, 8'hF0, 8'h0F, 8'h00, 4'b0101);

        // CLRF after C=1, B=1.
        op1("sub_b", OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1011);
        op1("clrf", OP_CLRF, 8'h00, 8'h00, 8'h00, 4'b0100);

        // Reserved opcode keeps C/B.
        op1("add_c", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0101);
        op1("sub_b2", OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1011);
        op1("rsvd", OP_RSVD, 8'h03, 8'h05, 8'h00, 4'b1111);

        op1("and",  OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0011);
        op1("shr",  OP_SHR, 8'h01, 8'h00, 8'h00, 4'b0111);
        op1("xor",  OP_XOR, 8'hAA, 8'h55, 8'hFF, 4'b0011);

        // Reset in the 3rd busy cycle of a MUL: clean state, no done ever.
        issue(OP_MUL, 8'hFF, 8'hFF);
        check("abort.busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.result", 32'(result), 32'h0);
        check("abort.flags",  32'(flags),  32'h0);
        check("abort.busy_cleared", 32'(busy), 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                if (done) seen++;
                @(posedge clk); #1;
            end
            check("abort.no_done", 32'(seen), 32'd0);
        end

        // The ALU is usable again after the abort.
        op1("post_add", OP_ADD, 8'h12, 8'h34, 8'h46, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
